// File: rtl/pool_ctrl_pkg.sv
// Shared types and size helpers for the pool frame controller.
// Imported by pool_frame_ctrl and pool_ctrl_wdog.
package pool_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } pool_ctrl_state_t;

    function automatic int nbeat(input int w, input int h);
        return w * h;
    endfunction

    function automatic int npool(input int w, input int h);
        return (w / 2) * (h / 2);
    endfunction

endpackage

// File: rtl/pool_ctrl_wdog.sv
// Idle watchdog for the pool frame controller.
// Built only when POOL_CTRL_WDOG_EN is defined.
import pool_ctrl_pkg::*;

module pool_ctrl_wdog #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic kick,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    assign expire = en & (cnt == CW'(TIMEOUT_CYC));

    always_ff @(posedge clk) begin
        if (rst || !en || kick) begin
            cnt <= '0;
        end else if (!expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pool_frame_ctrl.sv
// Frame sequencer between the conv stream and the 2x2 max-pool stage.
// Optional idle watchdog enabled with POOL_CTRL_WDOG_EN.
import pool_ctrl_pkg::*;

module pool_frame_ctrl #(
    parameter int CONV_WIDTH  = 24,
    parameter int CONV_HEIGHT = 24,
    parameter int COL_BIT     = 5,
    parameter int ROW_BIT     = 5,
    parameter int OCNT_BIT    = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                conv_valid,
    output logic                conv_ready,
    output logic                pool_valid_in,
    output logic                pool_clear,
    input  logic                pool_valid_out,
    output logic                busy,
    output logic                frame_done,
    output logic [COL_BIT-1:0]  col_idx,
    output logic [ROW_BIT-1:0]  row_idx,
    output logic [OCNT_BIT-1:0] out_count,
    output logic                err_overrun,
    output logic                err_extra,
    output logic                err_timeout
);

    localparam int NPOOL = npool(CONV_WIDTH, CONV_HEIGHT);
    localparam logic [COL_BIT-1:0]  COL_LAST = COL_BIT'(CONV_WIDTH - 1);
    localparam logic [ROW_BIT-1:0]  ROW_LAST = ROW_BIT'(CONV_HEIGHT - 1);
    localparam logic [OCNT_BIT-1:0] OCNT_MAX = OCNT_BIT'(NPOOL);

    pool_ctrl_state_t state, state_nx;

    logic beat;
    logic pv_cnt;
    logic full;
    logic cnt_hit;
    logic last_beat;
    logic wd_exp;

    assign conv_ready    = (state == ST_RUN);
    assign beat          = conv_valid & conv_ready;
    assign pool_valid_in = beat;
    assign pool_clear    = (state == ST_CLEAR);
    assign busy          = (state != ST_IDLE);

    // Pool results only count while a frame is open
    assign pv_cnt = pool_valid_out &
                    ((state == ST_CLEAR) | (state == ST_RUN) |
                     (state == ST_DRAIN));
    assign full    = (out_count == OCNT_MAX);
    assign cnt_hit = full | (pv_cnt & (out_count == OCNT_MAX - 1'b1));
    assign last_beat = beat & (row_idx == ROW_LAST) &
                       (col_idx == COL_LAST);

`ifdef POOL_CTRL_WDOG_EN
    pool_ctrl_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .en     ((state == ST_RUN) | (state == ST_DRAIN)),
        .kick   (beat | pool_valid_out),
        .expire (wd_exp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            err_timeout <= 1'b0;
        end else if (wd_exp) begin
            err_timeout <= 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg  = ^TIMEOUT_CYC;
    assign wd_exp      = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:  if (start) state_nx = ST_CLEAR;
            ST_CLEAR: state_nx = ST_RUN;
            ST_RUN: begin
                if (wd_exp)         state_nx = ST_DONE;
                else if (last_beat) state_nx = ST_DRAIN;
            end
            ST_DRAIN: if (wd_exp || cnt_hit) state_nx = ST_DONE;
            ST_DONE:  state_nx = ST_IDLE;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done  <= 1'b0;
            col_idx     <= '0;
            row_idx     <= '0;
            out_count   <= '0;
            err_overrun <= 1'b0;
            err_extra   <= 1'b0;
        end else begin
            frame_done <= (state == ST_DONE);
            if (state == ST_IDLE && start) begin
                col_idx     <= '0;
                row_idx     <= '0;
                out_count   <= '0;
                err_overrun <= 1'b0;
                err_extra   <= 1'b0;
            end
            if (beat) begin
                if (col_idx == COL_LAST) begin
                    col_idx <= '0;
                    row_idx <= (row_idx == ROW_LAST) ? '0 : row_idx + 1'b1;
                end else begin
                    col_idx <= col_idx + 1'b1;
                end
            end
            if (pv_cnt) begin
                if (full) err_extra <= 1'b1;
                else      out_count <= out_count + 1'b1;
            end
            // A dropped beat is flagged even on the cycle start is taken
            if (conv_valid && !conv_ready) err_overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pool_frame_ctrl.sv
// Scoreboard bench for pool_frame_ctrl (4x4 map, 16-cycle watchdog).
// Define POOL_CTRL_WDOG_EN to exercise the watchdog path.
module tb_pool_frame_ctrl;

    logic       clk = 0;
    logic       rst = 1;
    logic       start = 0;
    logic       conv_valid = 0;
    logic       pool_valid_out = 0;
    logic       conv_ready, pool_valid_in, pool_clear, busy, frame_done;
    logic [4:0] col_idx, row_idx;
    logic [7:0] out_count;
    logic       err_overrun, err_extra, err_timeout;

    pool_frame_ctrl #(
        .CONV_WIDTH(4), .CONV_HEIGHT(4), .COL_BIT(5), .ROW_BIT(5),
        .OCNT_BIT(8), .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .conv_valid(conv_valid),
        .conv_ready(conv_ready), .pool_valid_in(pool_valid_in),
        .pool_clear(pool_clear), .pool_valid_out(pool_valid_out),
        .busy(busy), .frame_done(frame_done), .col_idx(col_idx),
        .row_idx(row_idx), .out_count(out_count),
        .err_overrun(err_overrun), .err_extra(err_extra),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int oc;
        int ov;
        int ex;
        int to;
        int pvi;
    } exp_t;

    exp_t done_q[$];
    int   beat_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pvi_cnt = 0;
    int   clr_cnt = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents an output
    always @(negedge clk) begin
        if (rst) begin
            pvi_cnt = 0;
            clr_cnt = 0;
        end else begin
            if (pool_valid_in) begin
                pvi_cnt++;
                if (beat_q.size() == 0) begin
                    chk("pvi_unexpected", 1, 0);
                end else begin
                    int b;
                    b = beat_q.pop_front();
                    chk("beat_col", int'(col_idx), b % 16);
                    chk("beat_row", int'(row_idx), b / 16);
                end
            end
            if (pool_clear) clr_cnt++;
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = done_q.pop_front();
                    chk("done_count", int'(out_count), e.oc);
                    chk("done_overrun", int'(err_overrun), e.ov);
                    chk("done_extra", int'(err_extra), e.ex);
                    chk("done_timeout", int'(err_timeout), e.to);
                    chk("done_pvi_total", pvi_cnt, e.pvi);
                    chk("done_clear_pulses", clr_cnt, 1);
                end
                pvi_cnt = 0;
                clr_cnt = 0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_conv_ready"}, int'(conv_ready), 0);
        chk({tag, "_pool_valid_in"}, int'(pool_valid_in), 0);
        chk({tag, "_pool_clear"}, int'(pool_clear), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_col"}, int'(col_idx), 0);
        chk({tag, "_row"}, int'(row_idx), 0);
        chk({tag, "_out_count"}, int'(out_count), 0);
        chk({tag, "_err_overrun"}, int'(err_overrun), 0);
        chk({tag, "_err_extra"}, int'(err_extra), 0);
        chk({tag, "_err_timeout"}, int'(err_timeout), 0);
    endtask

    task automatic do_reset();
        rst = 1;
        start = 0;
        conv_valid = 0;
        pool_valid_out = 0;
        cyc();
        cyc();
        rst = 0;
        beat_q.delete();
        check_idle("reset");
    endtask

    task automatic start_frame();
        int ok;
        start = 1;
        cyc();
        start = 0;
        chk("start_clears_overrun", int'(err_overrun), 0);
        chk("start_clears_extra", int'(err_extra), 0);
        ok = 0;
        for (int i = 0; i < 5; i++) begin
            if (conv_ready) begin
                ok = 1;
                break;
            end
            cyc();
        end
        chk("run_entry_timeout", ok, 1);
    endtask

    task automatic send_beat(int k, int gap, logic pv);
        conv_valid = 1;
        pool_valid_out = pv;
        beat_q.push_back((k / 4) * 16 + (k % 4));
        cyc();
        conv_valid = 0;
        pool_valid_out = 0;
        repeat (gap) cyc();
    endtask

    task automatic pool_out(int n);
        for (int i = 0; i < n; i++) begin
            pool_valid_out = 1;
            cyc();
            pool_valid_out = 0;
            cyc();
        end
    endtask

    task automatic wait_idle(int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin
                ok = 1;
                break;
            end
            cyc();
        end
        chk("wait_idle_timeout", ok, 1);
        cyc();
        cyc();
    endtask

    int gaps[16] = '{0, 2, 1, 3, 0, 0, 3, 1, 2, 0, 1, 3, 2, 0, 1, 2};

    initial begin
        do_reset();

        // 1: nominal frame
        done_q.push_back('{oc: 4, ov: 0, ex: 0, to: 0, pvi: 16});
        start_frame();
        for (int k = 0; k < 16; k++) send_beat(k, 0, 1'b0);
        chk("drain_conv_ready", int'(conv_ready), 0);
        chk("drain_busy", int'(busy), 1);
        pool_out(4);
        wait_idle(10);
        chk("t1_busy_end", int'(busy), 0);
        chk("t1_out_count", int'(out_count), 4);

        // 2: gapped input
        done_q.push_back('{oc: 4, ov: 0, ex: 0, to: 0, pvi: 16});
        start_frame();
        for (int k = 0; k < 16; k++) send_beat(k, gaps[k], 1'b0);
        chk("t2_col_wrap", int'(col_idx), 0);
        chk("t2_row_wrap", int'(row_idx), 0);
        pool_out(4);
        wait_idle(10);

        // 3: overrun in IDLE and in DRAIN
        conv_valid = 1;
        #1;
        chk("t3_idle_pvi", int'(pool_valid_in), 0);
        cyc();
        conv_valid = 0;
        chk("t3_idle_overrun", int'(err_overrun), 1);
        done_q.push_back('{oc: 4, ov: 1, ex: 0, to: 0, pvi: 16});
        start_frame();
        for (int k = 0; k < 16; k++) send_beat(k, 0, 1'b0);
        conv_valid = 1;
        #1;
        chk("t3_drain_pvi", int'(pool_valid_in), 0);
        cyc();
        conv_valid = 0;
        chk("t3_drain_overrun", int'(err_overrun), 1);
        pool_out(4);
        wait_idle(10);

        // 4: extra pool output in the first DRAIN cycle
        done_q.push_back('{oc: 4, ov: 0, ex: 1, to: 0, pvi: 16});
        start_frame();
        for (int k = 0; k < 16; k++)
            send_beat(k, 0, (k % 3 == 2 && k < 12) ? 1'b1 : 1'b0);
        chk("t4_count_before", int'(out_count), 4);
        pool_out(1);
        wait_idle(10);
        chk("t4_extra", int'(err_extra), 1);
        chk("t4_count_hold", int'(out_count), 4);

        // 5: reset mid-frame
        start_frame();
        for (int k = 0; k < 7; k++) send_beat(k, 0, 1'b0);
        do_reset();
        repeat (3) cyc();
        chk("t5_no_done", int'(frame_done), 0);
        done_q.push_back('{oc: 4, ov: 0, ex: 0, to: 0, pvi: 16});
        start_frame();
        for (int k = 0; k < 16; k++) send_beat(k, 0, 1'b0);
        pool_out(4);
        wait_idle(10);

        // 6: stall after 9 beats
`ifdef POOL_CTRL_WDOG_EN
        done_q.push_back('{oc: 0, ov: 0, ex: 0, to: 1, pvi: 9});
        start_frame();
        for (int k = 0; k < 9; k++) send_beat(k, 0, 1'b0);
        repeat (10) cyc();
        chk("t6_no_early_timeout", int'(err_timeout), 0);
        wait_idle(30);
        chk("t6_timeout", int'(err_timeout), 1);
`else
        start_frame();
        for (int k = 0; k < 9; k++) send_beat(k, 0, 1'b0);
        repeat (40) cyc();
        chk("t6_still_busy", int'(busy), 1);
        chk("t6_still_run", int'(conv_ready), 1);
        chk("t6_timeout_tied", int'(err_timeout), 0);
        do_reset();
`endif

        repeat (3) cyc();
        chk("pending_done", done_q.size(), 0);
        chk("pending_beats", beat_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=1 required=0");
        $fatal(1, "simulation time limit");
    end

endmodule
